act_collector: RTL



---
 rtl/act_collector.sv | 105 ++++++++++
 1 files changed

// File: rtl/act_collector.sv
// Bias-add, saturate and ReLU/leaky-ReLU each accumulated sum into a result
// bank, then stream the full bank downstream over a valid/ready handshake.
module act_collector #(
    parameter int DATA_W      = 16,
    parameter int N_NEURON    = 8,
    parameter int LEAKY_SHIFT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] sum_in,
    input  logic              sum_valid,
    input  logic [DATA_W-1:0] bias_in,
    input  logic              act_sel,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              sat_flag,
    output logic              drop_flag
);

    localparam int IDX_W = $clog2(N_NEURON);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_NEURON - 1);

    typedef enum logic {
        COLLECT,
        DRAIN
    } state_t;

    state_t                   state;
    logic [IDX_W-1:0]         wr_idx;
    logic [IDX_W-1:0]         rd_idx;
    logic [DATA_W-1:0]        bank [N_NEURON];

    logic [DATA_W:0]          s_ext;
    logic                     sat_hit;
    logic signed [DATA_W-1:0] s_sat;
    logic [DATA_W-1:0]        act_val;

    // One extra bit catches overflow; the top two bits differ only when clipped.
    always_comb begin
        s_ext   = {sum_in[DATA_W-1], sum_in} + {bias_in[DATA_W-1], bias_in};
        sat_hit = s_ext[DATA_W] ^ s_ext[DATA_W-1];
        s_sat   = s_ext[DATA_W-1:0];
        if (sat_hit) begin
            s_sat = s_ext[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}}
                                  : {1'b0, {(DATA_W-1){1'b1}}};
        end
        act_val = s_sat;
        if (s_sat[DATA_W-1]) begin
            act_val = act_sel ? DATA_W'(s_sat >>> LEAKY_SHIFT) : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= COLLECT;
            wr_idx    <= '0;
            rd_idx    <= '0;
            sat_flag  <= 1'b0;
            drop_flag <= 1'b0;
            for (int i = 0; i < N_NEURON; i++) begin
                bank[i] <= '0;
            end
        end else begin
            unique case (state)
                COLLECT: begin
                    if (sum_valid) begin
                        bank[wr_idx] <= act_val;
                        if (sat_hit) begin
                            sat_flag <= 1'b1;
                        end
                        if (wr_idx == LAST) begin
                            wr_idx <= '0;
                            state  <= DRAIN;
                        end else begin
                            wr_idx <= wr_idx + IDX_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (sum_valid) begin
                        drop_flag <= 1'b1;
                    end
                    if (out_ready) begin
                        if (rd_idx == LAST) begin
                            rd_idx <= '0;
                            state  <= COLLECT;
                        end else begin
                            rd_idx <= rd_idx + IDX_W'(1);
                        end
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

    assign out_valid = (state == DRAIN);
    assign busy      = out_valid;
    assign out_data  = bank[rd_idx];
    assign out_last  = out_valid && (rd_idx == LAST);

endmodule
